// File: rtl/dram_word_adapter.sv
// dram_word_adapter
//   Bridges a 32-bit CPU word port to the 128-bit line port of dram_controller.
//   Reads fetch the enclosing line and return the selected word. DRAM has no
//   byte mask, so writes are read-modify-write: fetch the line, merge the
//   strobed bytes, then write the whole line back. One CPU request in flight.
//
//   Optional macro DRAM_WORD_ADAPTER_LINEBUF_EN adds a one-line buffer
//   (valid, tag addr[27:4], line). Read hits answer without DRAM traffic,
//   write hits skip the fetch and write the merged line straight through.
//
// Ports
//   ui_clk, sys_rst              clock, synchronous active-low reset
//   cpu_req_valid/ready          CPU request handshake (ready only in IDLE)
//   cpu_req_we/addr/wdata/wstrb  request fields, addr[1:0] and [31:28] ignored
//   cpu_rsp_valid/rdata          one-cycle response pulse, rdata 0 for writes
//   dram_req_en/rdy              DRAM request handshake
//   dram_req_cmd/addr/data       1=read 0=write, line address, write line
//   dram_rsp_en/data             DRAM read line return
//
// State table
//   state      | meaning
//   ST_IDLE    | ready for a CPU request
//   ST_RD_REQ  | line read request presented, waiting for dram_req_rdy
//   ST_RD_WAIT | waiting for the returned line
//   ST_WR_REQ  | merged line write presented, waiting for dram_req_rdy
//   ST_RESP    | one-cycle CPU response pulse

module dram_word_adapter (
    input  logic         ui_clk,
    input  logic         sys_rst,
    input  logic         cpu_req_valid,
    output logic         cpu_req_ready,
    input  logic         cpu_req_we,
    input  logic [31:0]  cpu_req_addr,
    input  logic [31:0]  cpu_req_wdata,
    input  logic [3:0]   cpu_req_wstrb,
    output logic         cpu_rsp_valid,
    output logic [31:0]  cpu_rsp_rdata,
    output logic         dram_req_en,
    input  logic         dram_req_rdy,
    output logic         dram_req_cmd,
    output logic [26:0]  dram_req_addr,
    output logic [127:0] dram_req_data,
    input  logic         dram_rsp_en,
    input  logic [127:0] dram_rsp_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic         we_q;
    logic [23:0]  line_addr_q;
    logic [1:0]   word_sel_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;
    logic [127:0] line_q;

    logic accept;
    logic noop_wr;
    logic buf_hit;
    logic rsp_take;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{cpu_req_addr[31:28], cpu_req_addr[1:0]};

    function automatic logic [31:0] word_of(input logic [127:0] line,
                                            input logic [1:0]   sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

    function automatic logic [127:0] merge_line(input logic [127:0] line,
                                                input logic [1:0]   sel,
                                                input logic [31:0]  wdata,
                                                input logic [3:0]   wstrb);
        logic [127:0] m;
        m = line;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                m[{sel, 5'b00000} + 7'(8 * b) +: 8] = wdata[8 * b +: 8];
            end
        end
        return m;
    endfunction

    assign accept   = (state == ST_IDLE) && cpu_req_valid;
    assign noop_wr  = cpu_req_we && (cpu_req_wstrb == 4'b0000);
    assign rsp_take = (state == ST_RD_WAIT) && dram_rsp_en;

`ifdef DRAM_WORD_ADAPTER_LINEBUF_EN
    // line_q doubles as the buffered line; only valid and tag live here.
    logic        buf_valid;
    logic [23:0] buf_tag;

    assign buf_hit = buf_valid && (buf_tag == cpu_req_addr[27:4]);

    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else if (rsp_take) begin
            buf_valid <= 1'b1;
            buf_tag   <= line_addr_q;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        dram_req_en   = 1'b0;
        dram_req_cmd  = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    if (noop_wr) begin
                        state_nxt = ST_RESP;
                    end else if (buf_hit) begin
                        state_nxt = cpu_req_we ? ST_WR_REQ : ST_RESP;
                    end else begin
                        state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                dram_req_en  = 1'b1;
                dram_req_cmd = 1'b1;
                if (dram_req_rdy) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (dram_rsp_en) begin
                    state_nxt = we_q ? ST_WR_REQ : ST_RESP;
                end
            end
            ST_WR_REQ: begin
                dram_req_en = 1'b1;
                if (dram_req_rdy) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                cpu_rsp_valid = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            we_q          <= 1'b0;
            line_addr_q   <= '0;
            word_sel_q    <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            line_q        <= '0;
            cpu_rsp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q          <= cpu_req_we;
                line_addr_q   <= cpu_req_addr[27:4];
                word_sel_q    <= cpu_req_addr[3:2];
                wdata_q       <= cpu_req_wdata;
                wstrb_q       <= cpu_req_wstrb;
                cpu_rsp_rdata <= '0;
                // Buffer hit: serve from / merge into the held line directly.
                if (buf_hit && !noop_wr) begin
                    if (cpu_req_we) begin
                        line_q <= merge_line(line_q, cpu_req_addr[3:2],
                                             cpu_req_wdata, cpu_req_wstrb);
                    end else begin
                        cpu_rsp_rdata <= word_of(line_q, cpu_req_addr[3:2]);
                    end
                end
            end
            if (rsp_take) begin
                if (we_q) begin
                    line_q <= merge_line(dram_rsp_data, word_sel_q, wdata_q, wstrb_q);
                end else begin
                    line_q        <= dram_rsp_data;
                    cpu_rsp_rdata <= word_of(dram_rsp_data, word_sel_q);
                end
            end
        end
    end

    assign dram_req_addr = {line_addr_q, 3'b000};
    assign dram_req_data = line_q;

endmodule
